// File: rtl/seg_display_arbiter_if.sv
// Display-sharing bus between the requesters and the 7-segment arbiter.
// The master side (requesters) drives requests, patterns and blank.
// The slave side (arbiter) returns the grant, the owner and the segment pattern.
interface seg_display_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    req;
  logic [32*NUM_REQ-1:0] req_data;
  logic                  blank;
  logic [NUM_REQ-1:0]    grant;
  logic [OW-1:0]         owner_id;
  logic                  busy;
  logic [31:0]           seg_values;

  modport master (
    output req, req_data, blank,
    input  grant, owner_id, busy, seg_values
  );

  modport slave (
    input  req, req_data, blank,
    output grant, owner_id, busy, seg_values
  );
endinterface

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the shared 4-digit 7-segment display.
// An owner keeps the display for at least DWELL_CYCLES cycles while others wait.
// The owner keeps it indefinitely when nobody else asks.
// All outputs are registered. The segment pattern is active-low, with byte0 as the rightmost digit.
module seg_display_arbiter #(
  parameter int          NUM_REQ       = 4,
  parameter int          DWELL_CYCLES  = 1000000,
  parameter logic [31:0] BLANK_PATTERN = 32'hFFFF_FFFF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seg_display_arbiter_if.slave  bus
);
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DWELL_CYCLES - 1);
  localparam logic [OW-1:0] LAST_ID = OW'(NUM_REQ - 1);

  typedef enum logic {ST_IDLE, ST_SHOW} state_t;

  state_t               r_state,  w_state_next;
  logic [NUM_REQ-1:0]   r_grant,  w_grant_next;
  logic [OW-1:0]        r_owner,  w_owner_next;
  logic [OW-1:0]        r_rr,     w_rr_next;
  logic                 r_busy,   w_busy_next;
  logic [31:0]          r_seg,    w_seg_next;
  logic [CW-1:0]        r_cnt,    w_cnt_next;

  logic [NUM_REQ-1:0]   w_mask;
  logic                 w_found;
  logic [OW-1:0]        w_pick;
  logic                 w_owner_req;
  logic                 w_expired;
  logic                 w_take;
  logic [31:0]          w_owner_data;
  logic [31:0]          w_pick_data;

  // While showing, r_rr is owner+1, so searching from r_rr with the owner masked out yields "next after owner".
  assign w_mask       = bus.req & ~r_grant;
  assign w_owner_req  = bus.req[r_owner];
  assign w_expired    = (r_cnt == CNT_MAX);
  assign w_owner_data = bus.req_data[32*r_owner +: 32];
  assign w_pick_data  = bus.req_data[32*w_pick +: 32];

  // Round-robin search: first masked request at or after r_rr, wrapping at NUM_REQ-1.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_pick  = '0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(r_rr) + k) % NUM_REQ;
      if (!w_found && w_mask[idx]) begin
        w_found = 1'b1;
        w_pick  = OW'(idx);
      end
    end
  end

  // Next state and next registered outputs. A take grants w_pick with a fresh dwell count.
  always_comb begin
    w_state_next = r_state;
    w_grant_next = r_grant;
    w_owner_next = r_owner;
    w_rr_next    = r_rr;
    w_busy_next  = r_busy;
    w_cnt_next   = r_cnt;
    w_seg_next   = BLANK_PATTERN;
    w_take       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_take = w_found;
      end
      ST_SHOW: begin
        if ((!w_owner_req || w_expired) && w_found) begin
          w_take = 1'b1;
        end else if (!w_owner_req) begin
          // The owner released and nobody is waiting, so the display blanks.
          w_state_next = ST_IDLE;
          w_grant_next = '0;
          w_owner_next = '0;
          w_busy_next  = 1'b0;
          w_cnt_next   = '0;
        end else begin
          if (!w_expired) w_cnt_next = r_cnt + CW'(1);
          w_seg_next = bus.blank ? BLANK_PATTERN : w_owner_data;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    if (w_take) begin
      w_state_next = ST_SHOW;
      w_grant_next = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick;
      w_owner_next = w_pick;
      w_rr_next    = (w_pick == LAST_ID) ? '0 : w_pick + 1'b1;
      w_busy_next  = 1'b1;
      w_cnt_next   = '0;
      w_seg_next   = bus.blank ? BLANK_PATTERN : w_pick_data;
    end
  end

  // State and output registers. Reset clears them immediately, without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_owner <= '0;
      r_rr    <= '0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_seg   <= BLANK_PATTERN;
    end else begin
      r_state <= w_state_next;
      r_grant <= w_grant_next;
      r_owner <= w_owner_next;
      r_rr    <= w_rr_next;
      r_busy  <= w_busy_next;
      r_cnt   <= w_cnt_next;
      r_seg   <= w_seg_next;
    end
  end

  assign bus.grant      = r_grant;
  assign bus.owner_id   = r_owner;
  assign bus.busy       = r_busy;
  assign bus.seg_values = r_seg;
endmodule
